// File: rtl/mult_accumulator_if.sv
// rtl/mult_accumulator_if.sv - product/tag input and frame-sum output bundle for mult_accumulator
interface mult_accumulator_if #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 40
);
    logic                  in_valid;
    logic                  in_last;
    logic [2*WIDTH-1:0]    prod;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_W-1:0]      out_data;
    logic                  out_sat;
    logic                  overrun;
    logic                  busy;

    modport master (
        output in_valid, in_last, prod, out_ready,
        input  out_valid, out_data, out_sat, overrun, busy
    );

    modport slave (
        input  in_valid, in_last, prod, out_ready,
        output out_valid, out_data, out_sat, overrun, busy
    );
endinterface

// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - frame dot-product accumulator behind a fixed-latency multiplier (optional MAC_SAT_EN)
module mult_accumulator #(
    parameter int WIDTH    = 16,
    parameter int MULT_LAT = 3,
    parameter int ACC_W    = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_accumulator_if.slave bus
);

    logic [MULT_LAT-1:0] tag_v;
    logic [MULT_LAT-1:0] tag_l;
    logic                tap_v;
    logic                tap_l;
    logic                completion;
    logic                first;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    sum_val;
    logic                out_valid_r;
    logic [ACC_W-1:0]    out_data_r;
    logic                overrun_r;
`ifdef MAC_SAT_EN
    logic [ACC_W:0]      sum_ext;
    logic                sat_now;
    logic                sat_flag;
    logic                out_sat_r;
`endif

    assign tap_v      = tag_v[MULT_LAT-1];
    assign tap_l      = tag_l[MULT_LAT-1];
    assign completion = tap_v & tap_l;

    // Running sum including the product now at the tap; a first term restarts from zero
    always_comb begin
`ifdef MAC_SAT_EN
        sum_ext = (first ? '0 : {1'b0, acc}) + (ACC_W+1)'(bus.prod);
        sum_val = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        sat_now = sum_ext[ACC_W] | (~first & sat_flag);
`else
        sum_val = (first ? '0 : acc) + ACC_W'(bus.prod);
`endif
    end

    // Tag pipe: delays {in_valid, in_last} to line up with the multiplier product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            tag_l <= '0;
        end else begin
            tag_v[0] <= bus.in_valid;
            tag_l[0] <= bus.in_last;
            for (int i = 1; i < MULT_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_l[i] <= tag_l[i-1];
            end
        end
    end

    // Accumulator: holds across gaps; the completing sum goes to the output path instead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            first <= 1'b1;
`ifdef MAC_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else if (tap_v) begin
            first <= tap_l;
            if (!tap_l) begin
                acc <= sum_val;
            end
`ifdef MAC_SAT_EN
            sat_flag <= sat_now;
`endif
        end
    end

    // One-entry result holding register; a completion that finds it full is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            overrun_r   <= 1'b0;
`ifdef MAC_SAT_EN
            out_sat_r   <= 1'b0;
`endif
        end else begin
            overrun_r <= 1'b0;
            if (completion && (!out_valid_r || bus.out_ready)) begin
                out_valid_r <= 1'b1;
                out_data_r  <= sum_val;
`ifdef MAC_SAT_EN
                out_sat_r   <= sat_now;
`endif
            end else if (completion) begin
                overrun_r <= 1'b1;
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.overrun   = overrun_r;
    assign bus.busy      = (|tag_v) | ~first;
`ifdef MAC_SAT_EN
    assign bus.out_sat   = out_sat_r;
`else
    assign bus.out_sat   = 1'b0;
`endif

endmodule
